// File: rtl/jt9346_ctrl.sv
// jt9346_ctrl: host-side master sequencer for a 93C46-compatible serial EEPROM.
// Turns one parallel command into an sclk/sdi/scs frame and polls ready/busy on sdo.
// Optional feature: define JT9346_CTRL_TIMEOUT_EN to abort busy polling after
// POLL_MAX samples (reported with rsp_err=1). Without it, polling waits indefinitely.
module jt9346_ctrl #(
  parameter int unsigned CLKDIV   = 4,
  parameter int unsigned POLL_MAX = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [5:0]  cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        sclk,
  output logic        sdi,
  output logic        scs,
  input  logic        sdo
);

  localparam int unsigned DIV_W    = 8;
  localparam int unsigned BIT_W    = 5;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned HDR_W    = 8;
  localparam int unsigned FRAME_W  = 1 + HDR_W + DATA_W;
  localparam int unsigned LEN_SHORT = 9;
  localparam int unsigned LEN_LONG  = 25;
  localparam int unsigned LEN_RDIN  = 17;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);

`ifdef JT9346_CTRL_TIMEOUT_EN
  localparam int unsigned POLL_W = $clog2(POLL_MAX + 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_MAX - 1);
`endif

  localparam logic [2:0] OP_READ  = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_ERASE = 3'd2;
  localparam logic [2:0] OP_EWEN  = 3'd3;
  localparam logic [2:0] OP_EWDS  = 3'd4;
  localparam logic [2:0] OP_ERAL  = 3'd5;
  localparam logic [2:0] OP_WRAL  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  // Parameter sanity checks at elaboration
  if (CLKDIV < 2 || CLKDIV > 255) begin : g_bad_clkdiv
    $error("jt9346_ctrl: CLKDIV must be in 2..255");
  end
  if (POLL_MAX < 1) begin : g_bad_poll_max
    $error("jt9346_ctrl: POLL_MAX must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_SHIFT_OUT,
    S_SHIFT_IN,
    S_CS_GAP,
    S_POLL,
    S_CS_END,
    S_RSP
  } state_t;

  state_t              state;
  logic [DIV_W-1:0]    div;
  logic [BIT_W-1:0]    bits_left;
  logic [FRAME_W-1:0]  sh_out;
  logic [2:0]          op_q;
  logic [DATA_W-1:0]   rd_sh;
  logic [1:0]          gap;
  logic                err_q;
`ifdef JT9346_CTRL_TIMEOUT_EN
  logic [POLL_W-1:0]   poll_cnt;
`endif

  logic [HDR_W-1:0]    hdr;
  logic                has_data;
  logic [FRAME_W-1:0]  frame;
  logic                tick;

  // Half-period strobe of the sclk divider
  assign tick = (div == DIV_LAST);

  // Opcode/address header and full outgoing frame for the command on the input port
  always_comb begin
    hdr = '0;
    case (cmd_op)
      OP_READ:  hdr = {2'b10, cmd_addr};
      OP_WRITE: hdr = {2'b01, cmd_addr};
      OP_ERASE: hdr = {2'b11, cmd_addr};
      OP_EWEN:  hdr = 8'b00_110000;
      OP_EWDS:  hdr = 8'b00_000000;
      OP_ERAL:  hdr = 8'b00_100000;
      OP_WRAL:  hdr = 8'b00_010000;
      default:  hdr = '0;
    endcase
    has_data = (cmd_op == OP_WRITE) || (cmd_op == OP_WRAL);
    frame    = {1'b1, hdr, (has_data ? cmd_wdata : {DATA_W{1'b0}})};
  end

  // Command sequencer: divider, bit shifting, chip-select framing and busy polling
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      div       <= '0;
      bits_left <= '0;
      sh_out    <= '0;
      op_q      <= '0;
      rd_sh     <= '0;
      gap       <= '0;
      err_q     <= 1'b0;
`ifdef JT9346_CTRL_TIMEOUT_EN
      poll_cnt  <= '0;
`endif
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      sclk      <= 1'b0;
      sdi       <= 1'b0;
      scs       <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      if (state != S_IDLE && state != S_RSP) begin
        div <= tick ? '0 : div + DIV_W'(1);
      end

      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            op_q      <= cmd_op;
            div       <= '0;
            err_q     <= 1'b0;
            if (cmd_op == OP_RSVD) begin
              err_q <= 1'b1;
              state <= S_RSP;
            end else begin
              // Start bit goes out with scs; first sclk rise is one half-period later
              scs       <= 1'b1;
              sdi       <= frame[FRAME_W-1];
              sh_out    <= {frame[FRAME_W-2:0], 1'b0};
              bits_left <= has_data ? BIT_W'(LEN_LONG) : BIT_W'(LEN_SHORT);
              state     <= S_CS_SETUP;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        S_CS_SETUP: begin
          if (tick) begin
            sclk  <= 1'b1;
            state <= S_SHIFT_OUT;
          end
        end

        S_SHIFT_OUT: begin
          if (tick) begin
            if (sclk) begin
              sclk      <= 1'b0;
              bits_left <= bits_left - BIT_W'(1);
              if (bits_left == BIT_W'(1)) begin
                sdi <= 1'b0;
                if (op_q == OP_READ) begin
                  bits_left <= BIT_W'(LEN_RDIN);
                  state     <= S_SHIFT_IN;
                end else if (op_q == OP_EWEN || op_q == OP_EWDS) begin
                  state <= S_CS_END;
                end else begin
                  gap   <= '0;
                  state <= S_CS_GAP;
                end
              end else begin
                sdi    <= sh_out[FRAME_W-1];
                sh_out <= {sh_out[FRAME_W-2:0], 1'b0};
              end
            end else begin
              sclk <= 1'b1;
            end
          end
        end

        S_SHIFT_IN: begin
          if (tick) begin
            if (sclk) begin
              // The first (dummy) sample falls off the top after 17 shifts
              sclk      <= 1'b0;
              rd_sh     <= {rd_sh[DATA_W-2:0], sdo};
              bits_left <= bits_left - BIT_W'(1);
              if (bits_left == BIT_W'(1)) begin
                state <= S_CS_END;
              end
            end else begin
              sclk <= 1'b1;
            end
          end
        end

        S_CS_GAP: begin
          // Half-period hold, scs low for a full sclk period, then reselect for polling
          if (tick) begin
            gap <= gap + 2'd1;
            if (gap == 2'd0) begin
              scs <= 1'b0;
            end else if (gap == 2'd2) begin
              scs   <= 1'b1;
`ifdef JT9346_CTRL_TIMEOUT_EN
              poll_cnt <= '0;
`endif
              state <= S_POLL;
            end
          end
        end

        S_POLL: begin
          if (tick) begin
            if (sdo) begin
              scs   <= 1'b0;
              state <= S_RSP;
            end else begin
`ifdef JT9346_CTRL_TIMEOUT_EN
              if (poll_cnt == POLL_LAST) begin
                scs   <= 1'b0;
                err_q <= 1'b1;
                state <= S_RSP;
              end else begin
                poll_cnt <= poll_cnt + POLL_W'(1);
              end
`endif
            end
          end
        end

        S_CS_END: begin
          if (tick) begin
            scs   <= 1'b0;
            state <= S_RSP;
          end
        end

        S_RSP: begin
          rsp_valid <= 1'b1;
          rsp_err   <= err_q;
          cmd_ready <= 1'b1;
          if (op_q == OP_READ) begin
            rsp_rdata <= rd_sh;
          end
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jt9346_ctrl.sv
// tb_jt9346_ctrl: scoreboard bench for jt9346_ctrl with a behavioural EEPROM slave
// and a word-level reference model. Timeout checks run when JT9346_CTRL_TIMEOUT_EN is defined.
module tb_jt9346_ctrl;

  localparam int unsigned CLKDIV = 4;
`ifdef JT9346_CTRL_TIMEOUT_EN
  localparam int unsigned POLL_MAX = 8;
`else
  localparam int unsigned POLL_MAX = 4096;
`endif

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [5:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        sclk;
  logic        sdi;
  logic        scs;
  logic        sdo;

  jt9346_ctrl #(.CLKDIV(CLKDIV), .POLL_MAX(POLL_MAX)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sclk(sclk), .sdi(sdi), .scs(scs), .sdo(sdo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  typedef struct { logic [15:0] rdata; logic err; } rsp_t;
  typedef struct { logic [31:0] bits; int len; } frm_t;
  rsp_t exp_rsp[$];
  frm_t exp_frm[$];
  frm_t cap_frm[$];

  // Word-level reference model
  logic [15:0] ref_mem [64];
  bit          ref_we;
  logic [15:0] ref_last;

  // Behavioural EEPROM slave
  logic [15:0] ee_mem [64];
  bit          ee_we;
  logic [31:0] ee_cap;
  int          ee_cnt;
  bit          ee_reading;
  logic        ee_bit;
  logic [15:0] ee_word;
  int          ee_busy;
  bit          ignore_frame;
  bit          force_busy;
  bit          inflight;
  bit          ready_leak;

  assign sdo = force_busy ? 1'b0 : (ee_reading ? ee_bit : ((ee_busy > 0) ? 1'b0 : 1'b1));

  initial begin
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = 16'hFFFF;
      ee_mem[i]  = 16'hFFFF;
    end
    ref_we = 0; ref_last = 16'h0000;
    ee_we = 0; ee_cap = '0; ee_cnt = 0; ee_reading = 0; ee_bit = 1'b0; ee_word = '0;
    ee_busy = 0; ignore_frame = 0; force_busy = 0; inflight = 0; ready_leak = 0;
  end

  // Slave: new frame on chip select
  always @(posedge scs) begin
    ee_cnt = 0;
    ee_cap = '0;
  end

  // Slave: shift in sdi on sclk rise, present read data one pulse ahead of the host's sample
  always @(posedge sclk) begin
    if (scs) begin
      ee_cap = {ee_cap[30:0], sdi};
      ee_cnt++;
      if (ee_cnt == 9 && ee_cap[8:6] == 3'b110) begin
        ee_reading = 1;
        ee_word    = ee_mem[ee_cap[5:0]];
        ee_bit     = 1'b0;
      end else if (ee_reading && ee_cnt >= 11 && ee_cnt <= 26) begin
        ee_bit = ee_word[26 - ee_cnt];
      end else if (ee_reading) begin
        ee_bit = 1'b0;
      end
    end
  end

  // Slave: frame completes on chip-select fall; execute it and go busy on programming
  always @(negedge scs) begin
    logic [8:0] h;
    frm_t f;
    bit prog;
    ee_reading = 0;
    prog = 0;
    if (ignore_frame) begin
      ignore_frame = 0;
    end else if (ee_cnt > 0) begin
      f.bits = ee_cap;
      f.len  = ee_cnt;
      cap_frm.push_back(f);
      if (ee_cnt >= 9) begin
        h = 9'(ee_cap >> (ee_cnt - 9));
        case (h[7:6])
          2'b01: if (ee_cnt == 25 && ee_we) begin ee_mem[h[5:0]] = ee_cap[15:0]; prog = 1; end
          2'b11: if (ee_cnt == 9 && ee_we) begin ee_mem[h[5:0]] = 16'hFFFF; prog = 1; end
          2'b00: begin
            case (h[5:4])
              2'b11: if (ee_cnt == 9) ee_we = 1;
              2'b00: if (ee_cnt == 9) ee_we = 0;
              2'b10: if (ee_cnt == 9 && ee_we) begin
                       for (int i = 0; i < 64; i++) ee_mem[i] = 16'hFFFF;
                       prog = 1;
                     end
              default: if (ee_cnt == 25 && ee_we) begin
                       for (int i = 0; i < 64; i++) ee_mem[i] = ee_cap[15:0];
                       prog = 1;
                     end
            endcase
          end
          default: ;
        endcase
      end
    end
    if (prog) ee_busy = int'($urandom_range(0, 50));
    ee_cnt = 0;
  end

  always @(negedge clk) if (ee_busy > 0) ee_busy--;

  // Frame checker: compare every captured frame with the next expected one
  always @(negedge clk) begin
    frm_t c, e;
    while (cap_frm.size() > 0) begin
      c = cap_frm.pop_front();
      if (exp_frm.size() == 0) begin
        chk("frame_unexpected", 32'(c.len), 32'd0);
      end else begin
        e = exp_frm.pop_front();
        chk("frame_len", 32'(c.len), 32'(e.len));
        chk("frame_bits", c.bits, e.bits);
      end
    end
  end

  // Response monitor: pop and compare on every rsp_valid; watch cmd_ready while busy
  always @(negedge clk) begin
    rsp_t e;
    if (!rst && inflight && cmd_ready && !rsp_valid) ready_leak = 1;
    if (!rst && rsp_valid) begin
      if (exp_rsp.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_rsp.pop_front();
        chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("scs_low_at_rsp", 32'(scs), 32'd0);
        chk("sclk_low_at_rsp", 32'(sclk), 32'd0);
        chk("ready_with_rsp", 32'(cmd_ready), 32'd1);
        chk("ready_low_while_busy", 32'(ready_leak), 32'd0);
      end
      inflight   = 0;
      ready_leak = 0;
    end
  end

  // Issue one command; updates the reference model and pushes expectations when track=1
  task automatic issue(input logic [2:0] op, input logic [5:0] addr, input logic [15:0] wd,
                       input bit track, input bit exp_err);
    int n;
    rsp_t r;
    frm_t f;
    logic [31:0] hdr;
    int opbits, afield;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
      return;
    end
    if (track) begin
      case (op)
        3'd0: ref_last = ref_mem[addr];
        3'd1: if (ref_we) ref_mem[addr] = wd;
        3'd2: if (ref_we) ref_mem[addr] = 16'hFFFF;
        3'd3: ref_we = 1;
        3'd4: ref_we = 0;
        3'd5: if (ref_we) for (int i = 0; i < 64; i++) ref_mem[i] = 16'hFFFF;
        3'd6: if (ref_we) for (int i = 0; i < 64; i++) ref_mem[i] = wd;
        default: ;
      endcase
      r.rdata = ref_last;
      r.err   = (op == 3'd7) || exp_err;
      exp_rsp.push_back(r);
      case (op)
        3'd0: begin opbits = 2; afield = int'(addr); end
        3'd1: begin opbits = 1; afield = int'(addr); end
        3'd2: begin opbits = 3; afield = int'(addr); end
        3'd3: begin opbits = 0; afield = 48; end
        3'd4: begin opbits = 0; afield = 0;  end
        3'd5: begin opbits = 0; afield = 32; end
        default: begin opbits = 0; afield = 16; end
      endcase
      hdr   = 32'(256 + opbits * 64 + afield);
      f.len = 9;
      f.bits = hdr;
      if (op == 3'd1 || op == 3'd6) begin f.bits = hdr * 65536 + 32'(wd); f.len = 25; end
      if (op == 3'd0) begin f.bits = hdr * 131072; f.len = 26; end
      if (op != 3'd7) exp_frm.push_back(f);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wd;
    @(posedge clk);
    #1;
    inflight   = 1;
    ready_leak = 0;
    if (op != 3'd7) begin
      cmd_op    = 3'($urandom);
      cmd_addr  = 6'($urandom);
      cmd_wdata = 16'($urandom);
      repeat (int'($urandom_range(1, 3))) @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_rsp.size() > 0 || exp_frm.size() > 0 || !cmd_ready) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int rises, n;
    logic prev;
    cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_wdata = '0;
    rst = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("reset_outputs", {13'd0, rsp_valid, rsp_err, sclk, sdi, scs, rsp_rdata[13:0]}, 32'd0);
    chk("reset_rdata", 32'(rsp_rdata), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", 32'(cmd_ready), 32'd1);

    // Directed sequence
    issue(3'd3, 6'h00, 16'h0000, 1, 0);
    issue(3'd1, 6'h05, 16'hA55A, 1, 0);
    issue(3'd0, 6'h05, 16'h0000, 1, 0);
    issue(3'd2, 6'h05, 16'h0000, 1, 0);
    issue(3'd0, 6'h05, 16'h0000, 1, 0);
    issue(3'd0, 6'h06, 16'h0000, 1, 0);
    issue(3'd6, 6'h00, 16'h1234, 1, 0);
    issue(3'd0, 6'h00, 16'h0000, 1, 0);
    issue(3'd0, 6'h3F, 16'h0000, 1, 0);
    issue(3'd7, 6'h12, 16'hBEEF, 1, 0);
    issue(3'd4, 6'h00, 16'h0000, 1, 0);
    issue(3'd1, 6'h07, 16'h5555, 1, 0);
    issue(3'd0, 6'h07, 16'h0000, 1, 0);
    issue(3'd3, 6'h00, 16'h0000, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), 6'($urandom), 16'($urandom), 1, 0);
    end
    drain();

    // Reset in the middle of a WRITE frame
    ignore_frame = 1;
    issue(3'd1, 6'h09, 16'hC3C3, 0, 0);
    rises = 0; n = 0; prev = sclk;
    while (rises < 12 && n < 2000) begin
      @(negedge clk);
      if (sclk && !prev) rises++;
      prev = sclk;
      n++;
    end
    chk("mid_write_rises", 32'(rises), 32'd12);
    rst = 1'b1;
    #1;
    chk("abort_serial_lines", {29'd0, scs, sclk, sdi}, 32'd0);
    chk("abort_handshake", {30'd0, cmd_ready, rsp_valid}, 32'd0);
    inflight = 0;
    ref_last = 16'h0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_abort", 32'(cmd_ready), 32'd1);
    issue(3'd0, 6'h09, 16'h0000, 1, 0);
    issue(3'd0, 6'h05, 16'h0000, 1, 0);
    drain();

`ifdef JT9346_CTRL_TIMEOUT_EN
    // Busy never clears: polling must give up with an error
    issue(3'd4, 6'h00, 16'h0000, 1, 0);
    drain();
    force_busy = 1;
    issue(3'd1, 6'h11, 16'h7777, 1, 1);
    drain();
    force_busy = 0;
    issue(3'd7, 6'h00, 16'h0000, 1, 0);
    issue(3'd0, 6'h11, 16'h0000, 1, 0);
    drain();
`endif

    repeat (10) @(negedge clk);
    chk("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);
    chk("frame_queue_empty", 32'(exp_frm.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
